vce_palette_engine: RTL and testbench
=====================================

// Module: vce_palette_engine
// PURPOSE
//  Parametrised video colour encoder: CPU-programmable colour RAM (CRAM) palette lookup.
//  Takes pixel indices from the VDC and emits registered RGB at a mode-selected pixel rate.
//  Adds registered pipelined lookup, sync blanking, greyscale mode and a prefetched CPU read buffer.
//  Sits between the VDC pixel bus and the VGA/TV output subsystem; CPU access is via an 8-bit MMIO window.
// PARAMETERS
//  CRAM_DEPTH  512  palette entries; power of 2, 16..1024; AW = $clog2(CRAM_DEPTH)
//  CBITS       3    bits per colour channel, 1..5; entry width EW = 3*CBITS, order {G,R,B}
//  DIV_LO      4    clock divide for mode 0 (slowest pixel clock)
//  DIV_MID     3    clock divide for mode 1
//  DIV_HI      2    clock divide for modes 2/3
// PORTS
//  clock      in   1      system clock
//  reset_N    in   1      asynchronous, active-low reset
//  VD         in   AW     pixel palette index from VDC
//  HSYN       in   1      active-low horizontal sync; blanks output while low
//  VSYN       in   1      active-low vertical sync; blanks output while low
//  bus_en     in   1      CPU bus clock enable; all MMIO sampling is qualified by it
//  A          in   3      MMIO register offset
//  D_in       in   8      CPU write data
//  D_out      out  8      CPU read data; 8'hFF for unmapped offsets
//  D_oe       out  1      high when ~RD_n & ~CS_n
//  RD_n       in   1      active-low read strobe
//  WR_n       in   1      active-low write strobe
//  CS_n       in   1      active-low chip select
//  VIDEO_R    out  CBITS  red
//  VIDEO_G    out  CBITS  green
//  VIDEO_B    out  CBITS  blue
//  blank      out  1      registered, aligned with RGB; high when output is forced to 0
//  clock_en   out  1      pixel clock enable, one clock wide
// BEHAVIOUR
//  Reset (async): CR=0, CTA=0, CTW=0, RBUF=0, RGB=0, blank=1, strobe history=1, divider counters=0.
//   CRAM contents are not reset.
//  Registers, all 8-bit:
//   0 CR: [1:0] mode, [7] greyscale.
//   2 CTA[7:0]; 3 CTA[AW-1:8].
//   4 write latches CTW[7:0]; read returns RBUF[7:0].
//   5 write commits CRAM[CTA] <= {D_in[EW-9:0],CTW}, then CTA++; read returns RBUF[EW-1:8] zero-extended, then CTA++.
//  Strobe detect: on each bus_en, prev_rd <= RD_n|CS_n and prev_wr <= WR_n|CS_n.
//   Access fires once per strobe, when bus_en & prev_x & ~x & ~CS_n.
//   Holding a strobe low never repeats the access.
//  CTA increment wraps CRAM_DEPTH-1 -> 0.
//  Read buffer: RBUF <= CRAM[CTA] on the clock after any CTA change or any CRAM write to CTA.
//   D_out is combinational from RBUF, so reads are valid from the strobe edge with no CRAM access in the read cycle.
//  Dual-port CRAM: CPU port R/W, pixel port read-only.
//   Same-address collision: the pixel port returns the old value; the write is visible from the next lookup.
//  Pixel clock: mode 0 -> DIV_LO, 1 -> DIV_MID, 2/3 -> DIV_HI.
//   A CR write resets the divider counter, so the first new-rate pulse comes DIV clocks later; no runt pulse.
//  Pixel pipeline, advancing only on clock_en; latency exactly 2 enables from VD/HSYN/VSYN sample to RGB.
//   S1: idx <= VD; sync_s1 <= HSYN & VSYN; ent <= CRAM[VD].
//   S2: if ~sync_s1 -> RGB=0, blank=1.
//       elif CR[7] -> R=G=B=Y, Y=(2*R+5*G+B)>>3 in CBITS+3-bit arithmetic, no overflow.
//       else RGB from ent; blank=0.
//  X on VD (simulation only) -> S2 outputs 0.
// STRUCTURE
//  Package vce_pkg: register offset localparams (VCE_CR, VCE_CTA_LO, VCE_CTA_HI, VCE_CTW, VCE_CTD),
//   typedef enum vce_mode_t {PIX_LO, PIX_MID, PIX_HI}, CR bit-position constants.
//  Sub-module vce_pixclk_gen: mode-selected divider with sync restart; replaces three free-running dividers.
//  CRAM is inferred as 2-port RAM.
// TESTING
//  1. CTA=0x1FF, write reg4=0xA5, reg5=0x01 -> CRAM[0x1FF]=0x1A5, CTA wraps to 0x000.
//  2. Preload CRAM[0]=0x0C3; CTA=0; read reg4 then reg5 -> 0xC3, 0x00; CTA=1; RBUF reloads CRAM[1].
//  3. RD_n held low 10 bus_en cycles on reg5 -> CTA advances exactly once.
//  4. Switch CR mode 0->1->2 -> clock_en period 4, 3, 2; first pulse after each switch is full period.
//  5. VD=7, CRAM[7]=0x1FF, syncs high -> RGB=7/7/7 two enables later; HSYN low -> RGB=0, blank=1 with same latency.
//  6. CR[7]=1, entry G=4,R=2,B=0 -> Y=(4+20+0)>>3=3 on all channels; CPU write to displayed index -> new colour next lookup.

Source files
------------

// File: rtl/vce_palette_engine_pkg.sv
// vce_palette_engine shared definitions: MMIO register map,
// CR bit positions and pixel-rate mode decode.
package vce_pkg;

    localparam logic [2:0] VCE_CR     = 3'd0;
    localparam logic [2:0] VCE_CTA_LO = 3'd2;
    localparam logic [2:0] VCE_CTA_HI = 3'd3;
    localparam logic [2:0] VCE_CTW    = 3'd4;
    localparam logic [2:0] VCE_CTD    = 3'd5;

    localparam int CR_MODE_LSB = 0;
    localparam int CR_MODE_W   = 2;
    localparam int CR_GREY     = 7;

    typedef enum logic [1:0] {
        PIX_LO,
        PIX_MID,
        PIX_HI
    } vce_mode_t;

    // modes 2 and 3 both run at the fastest rate
    function automatic vce_mode_t mode_dec(input logic [1:0] m);
        mode_dec = PIX_HI;
        unique case (1'b1)
            (m == 2'd0): mode_dec = PIX_LO;
            (m == 2'd1): mode_dec = PIX_MID;
            default:     mode_dec = PIX_HI;
        endcase
    endfunction

endpackage

// File: rtl/vce_palette_engine_if.sv
// vce_palette_engine CPU MMIO bus: 8-bit window with
// active-low strobes and a bus clock enable.
interface vce_palette_engine_if;

    logic       bus_en;
    logic [2:0] A;
    logic [7:0] D_in;
    logic [7:0] D_out;
    logic       D_oe;
    logic       RD_n;
    logic       WR_n;
    logic       CS_n;

    modport master (
        output bus_en, A, D_in, RD_n, WR_n, CS_n,
        input  D_out, D_oe
    );

    modport slave (
        input  bus_en, A, D_in, RD_n, WR_n, CS_n,
        output D_out, D_oe
    );

endinterface

// File: rtl/vce_palette_engine_pixclk_gen.sv
// vce_pixclk_gen: single mode-selected divider producing a
// one-clock pixel enable, restarted on every CR write.
module vce_pixclk_gen
    import vce_pkg::*;
#(
    parameter int DIV_LO  = 4,
    parameter int DIV_MID = 3,
    parameter int DIV_HI  = 2
) (
    input  logic      clock,
    input  logic      reset_N,
    input  vce_mode_t mode_i,
    input  logic      restart_i,
    output logic      clock_en_o
);

    localparam int CW = 8;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] div_m1;

    // terminal count for the selected rate
    always_comb begin
        div_m1 = CW'(DIV_HI - 1);
        unique case (1'b1)
            (mode_i == PIX_LO):  div_m1 = CW'(DIV_LO - 1);
            (mode_i == PIX_MID): div_m1 = CW'(DIV_MID - 1);
            default:             div_m1 = CW'(DIV_HI - 1);
        endcase
    end

    assign clock_en_o = (cnt_q == div_m1);

    // restart drops the count to 0 so the next pulse is a full period away
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart_i || clock_en_o)
            cnt_d = '0;
    end

    // divider counter
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/vce_palette_engine.sv
// vce_palette_engine: CPU-programmable CRAM palette lookup with
// sync blanking, greyscale and a prefetched CPU read buffer.
module vce_palette_engine
    import vce_pkg::*;
#(
    parameter int CRAM_DEPTH = 512,
    parameter int CBITS      = 3,
    parameter int DIV_LO     = 4,
    parameter int DIV_MID    = 3,
    parameter int DIV_HI     = 2,
    localparam int AW        = $clog2(CRAM_DEPTH),
    localparam int EW        = 3 * CBITS
) (
    input  logic                  clock,
    input  logic                  reset_N,
    vce_palette_engine_if.slave   bus,
    input  logic [AW-1:0]         VD,
    input  logic                  HSYN,
    input  logic                  VSYN,
    output logic [CBITS-1:0]      VIDEO_R,
    output logic [CBITS-1:0]      VIDEO_G,
    output logic [CBITS-1:0]      VIDEO_B,
    output logic                  blank,
    output logic                  clock_en
);

    localparam int YW = CBITS + 3;

    logic              prev_rd_q;
    logic              prev_wr_q;
    logic              rd_fire;
    logic              wr_fire;
    logic [1:0]        mode_q, mode_d;
    logic              grey_q, grey_d;
    logic [AW-1:0]     cta_q, cta_d;
    logic [7:0]        ctw_q, ctw_d;
    logic              cr_we;
    logic              cram_we;
    logic [EW-1:0]     cram_wd;
    logic              reload_q;
    logic [EW-1:0]     rbuf_q;
    logic [EW-1:0]     cram [CRAM_DEPTH];
    logic              pix_en;
    logic [EW-1:0]     ent_q;
    logic              sync_s1_q;
    logic [CBITS-1:0]  ent_r, ent_g, ent_b;
    logic [YW-1:0]     y_sum;
    logic [CBITS-1:0]  y;
    logic [CBITS-1:0]  r_q, g_q, b_q;
    logic [CBITS-1:0]  r_d, g_d, b_d;
    logic              blank_q, blank_d;

    assign rd_fire = bus.bus_en & prev_rd_q & ~bus.RD_n & ~bus.CS_n;
    assign wr_fire = bus.bus_en & prev_wr_q & ~bus.WR_n & ~bus.CS_n;

    // MMIO register decode; reads of CTD also advance the address
    always_comb begin
        mode_d  = mode_q;
        grey_d  = grey_q;
        cta_d   = cta_q;
        ctw_d   = ctw_q;
        cr_we   = 1'b0;
        cram_we = 1'b0;
        cram_wd = EW'({bus.D_in, ctw_q});
        if (wr_fire) begin
            unique case (1'b1)
                (bus.A == VCE_CR): begin
                    mode_d = bus.D_in[CR_MODE_LSB +: CR_MODE_W];
                    grey_d = bus.D_in[CR_GREY];
                    cr_we  = 1'b1;
                end
                (bus.A == VCE_CTA_LO):
                    cta_d = (cta_q & ~AW'(8'hFF)) | AW'(bus.D_in);
                (bus.A == VCE_CTA_HI):
                    cta_d = (cta_q & AW'(8'hFF)) | AW'({bus.D_in, 8'h00});
                (bus.A == VCE_CTW):
                    ctw_d = bus.D_in;
                (bus.A == VCE_CTD): begin
                    cram_we = 1'b1;
                    cta_d   = cta_q + AW'(1);
                end
                default: ;
            endcase
        end else if (rd_fire && bus.A == VCE_CTD) begin
            cta_d = cta_q + AW'(1);
        end
    end

    // CPU-side registers and strobe history
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            prev_rd_q <= 1'b1;
            prev_wr_q <= 1'b1;
            mode_q    <= '0;
            grey_q    <= 1'b0;
            cta_q     <= '0;
            ctw_q     <= '0;
            reload_q  <= 1'b0;
        end else begin
            if (bus.bus_en) begin
                prev_rd_q <= bus.RD_n | bus.CS_n;
                prev_wr_q <= bus.WR_n | bus.CS_n;
            end
            mode_q   <= mode_d;
            grey_q   <= grey_d;
            cta_q    <= cta_d;
            ctw_q    <= ctw_d;
            reload_q <= cram_we | (cta_d != cta_q);
        end
    end

    // CPU write port of the palette RAM
    always_ff @(posedge clock) begin
        if (cram_we)
            cram[cta_q] <= cram_wd;
    end

    // read buffer refreshes one clock after the address or entry changes
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N)
            rbuf_q <= '0;
        else if (reload_q)
            rbuf_q <= cram[cta_q];
    end

    // CPU read data comes straight from the buffer
    always_comb begin
        bus.D_out = 8'hFF;
        unique case (1'b1)
            (bus.A == VCE_CTW): bus.D_out = 8'(rbuf_q);
            (bus.A == VCE_CTD): bus.D_out = 8'(16'(rbuf_q) >> 8);
            default:            bus.D_out = 8'hFF;
        endcase
    end

    assign bus.D_oe = ~bus.RD_n & ~bus.CS_n;

    vce_pixclk_gen #(
        .DIV_LO  (DIV_LO),
        .DIV_MID (DIV_MID),
        .DIV_HI  (DIV_HI)
    ) u_pixclk (
        .clock      (clock),
        .reset_N    (reset_N),
        .mode_i     (mode_dec(mode_q)),
        .restart_i  (cr_we),
        .clock_en_o (pix_en)
    );

    assign clock_en = pix_en;

    // S1 lookup: a same-cycle CPU write leaves the old entry here
    always_ff @(posedge clock) begin
        if (pix_en)
            ent_q <= cram[VD];
    end

    // S1 sync capture
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N)
            sync_s1_q <= 1'b0;
        else if (pix_en)
            sync_s1_q <= HSYN & VSYN;
    end

    assign ent_g = ent_q[EW-1 -: CBITS];
    assign ent_r = ent_q[2*CBITS-1 -: CBITS];
    assign ent_b = ent_q[CBITS-1:0];
    assign y_sum = (YW'(ent_r) << 1) + (YW'(ent_g) << 2)
                 + YW'(ent_g) + YW'(ent_b);
    assign y     = CBITS'(y_sum >> 3);

    // S2 colour select: blanking wins over greyscale
    always_comb begin
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        blank_d = blank_q;
        if (pix_en) begin
            if (!sync_s1_q) begin
                r_d     = '0;
                g_d     = '0;
                b_d     = '0;
                blank_d = 1'b1;
            end else if (grey_q) begin
                r_d     = y;
                g_d     = y;
                b_d     = y;
                blank_d = 1'b0;
            end else begin
                r_d     = ent_r;
                g_d     = ent_g;
                b_d     = ent_b;
                blank_d = 1'b0;
            end
        end
    end

    // S2 output registers
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            blank_q <= 1'b1;
        end else begin
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            blank_q <= blank_d;
        end
    end

    assign VIDEO_R = r_q;
    assign VIDEO_G = g_q;
    assign VIDEO_B = b_q;
    assign blank   = blank_q;

endmodule

// File: tb/tb_vce_palette_engine.sv
// tb_vce_palette_engine: directed and random checks of the
// palette engine against a behavioural palette/register model.
module tb_vce_palette_engine;

    localparam int DEPTH = 512;

    logic       clock = 1'b0;
    logic       reset_N = 1'b0;
    logic [8:0] VD;
    logic       HSYN, VSYN;
    logic [2:0] VIDEO_R, VIDEO_G, VIDEO_B;
    logic       blank, clock_en;

    vce_palette_engine_if bus();

    vce_palette_engine dut (
        .clock    (clock),
        .reset_N  (reset_N),
        .bus      (bus),
        .VD       (VD),
        .HSYN     (HSYN),
        .VSYN     (VSYN),
        .VIDEO_R  (VIDEO_R),
        .VIDEO_G  (VIDEO_G),
        .VIDEO_B  (VIDEO_B),
        .blank    (blank),
        .clock_en (clock_en)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fire_cyc = 0;
    int pulses[$];

    int mcram[DEPTH];
    int mcta = 0;
    int mctw = 0;
    bit mgrey = 0;
    int written[$];

    int p_ent = 0;
    int p_sync = 0;
    bit p_valid = 0;

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (clock_en) pulses.push_back(cyc);

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bwr(input int a, input int d);
        @(posedge clock); #1;
        bus.A = 3'(a);
        bus.D_in = 8'(d);
        bus.CS_n = 1'b0;
        bus.WR_n = 1'b0;
        @(posedge clock); #1;
        fire_cyc = cyc;
        bus.WR_n = 1'b1;
        bus.CS_n = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        case (a)
            0: mgrey = ((d >> 7) & 1) != 0;
            2: mcta = (mcta & 'h100) | (d & 'hFF);
            3: mcta = (mcta & 'hFF) | ((d & 1) << 8);
            4: mctw = d & 'hFF;
            5: begin
                mcram[mcta] = ((d & 1) << 8) | mctw;
                written.push_back(mcta);
                mcta = (mcta + 1) % DEPTH;
            end
            default: ;
        endcase
    endtask

    task automatic brd(input int a, output int d, output int oe);
        @(posedge clock); #1;
        bus.A = 3'(a);
        bus.CS_n = 1'b0;
        bus.RD_n = 1'b0;
        #2;
        d = int'(bus.D_out);
        oe = int'(bus.D_oe);
        @(posedge clock); #1;
        bus.RD_n = 1'b1;
        bus.CS_n = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        if (a == 5) mcta = (mcta + 1) % DEPTH;
    endtask

    task automatic set_cta(input int addr);
        bwr(2, addr & 'hFF);
        bwr(3, addr >> 8);
    endtask

    task automatic wcram(input int addr, input int val);
        set_cta(addr);
        bwr(4, val & 'hFF);
        bwr(5, val >> 8);
    endtask

    task automatic rd_entry(input string tag);
        int d, oe, exp;
        exp = mcram[mcta];
        brd(4, d, oe);
        chk({tag, "_lo"}, d, exp & 'hFF);
        brd(5, d, oe);
        chk({tag, "_hi"}, d, exp >> 8);
    endtask

    function automatic int exp_pix(input int ent, input int sync, input bit grey);
        int g, r, b, y;
        g = (ent >> 6) & 7;
        r = (ent >> 3) & 7;
        b = ent & 7;
        if (sync == 0) return 'h200;
        if (grey) begin
            y = (2 * r + 5 * g + b) / 8;
            return (y << 6) | (y << 3) | y;
        end
        return (r << 6) | (g << 3) | b;
    endfunction

    task automatic wait_en;
        bit got;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (clock_en) got = 1;
        end
        chk("en_seen", int'(got), 1);
        @(posedge clock); #1;
    endtask

    task automatic pstep(input int vd, input int h, input int v,
                         input bit do_chk, input string tag);
        VD = 9'(vd);
        HSYN = h[0];
        VSYN = v[0];
        wait_en;
        if (do_chk && p_valid)
            chk(tag, int'({blank, VIDEO_R, VIDEO_G, VIDEO_B}),
                exp_pix(p_ent, p_sync, mgrey));
        p_ent = mcram[vd];
        p_sync = h & v;
        p_valid = 1;
    endtask

    task automatic chk_rate(input int mode, input int div, input string tag);
        int first, second, third, idx;
        pulses.delete();
        bwr(0, mode);
        repeat (16) @(posedge clock);
        #1;
        first = -1; second = -1; third = -1;
        idx = 0;
        foreach (pulses[i]) begin
            if (pulses[i] >= fire_cyc) begin
                if (idx == 0) first = pulses[i];
                else if (idx == 1) second = pulses[i];
                else if (idx == 2) third = pulses[i];
                idx++;
            end
        end
        chk({tag, "_first"}, first - fire_cyc + 1, div);
        chk({tag, "_per1"}, second - first, div);
        chk({tag, "_per2"}, third - second, div);
    endtask

    initial begin
        int d, oe, a, v, x;
        bus.bus_en = 1'b1;
        bus.A = 3'd0;
        bus.D_in = 8'd0;
        bus.RD_n = 1'b1;
        bus.WR_n = 1'b1;
        bus.CS_n = 1'b1;
        VD = 9'd0;
        HSYN = 1'b1;
        VSYN = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_pix", int'({blank, VIDEO_R, VIDEO_G, VIDEO_B}), 'h200);
        chk("rst_clken", int'(clock_en), 0);
        reset_N = 1'b1;
        chk("idle_oe", int'(bus.D_oe), 0);
        brd(4, d, oe);
        chk("rst_rbuf_lo", d, 0);
        chk("rd_oe", oe, 1);
        brd(1, d, oe);
        chk("unmapped", d, 'hFF);

        wcram(0, 'h0C3);
        wcram(1, 'h15A);
        set_cta('h1FF);
        bwr(4, 'hA5);
        bwr(5, 'h01);
        chk("t1_cta_wrap_model", mcta, 0);
        rd_entry("t2_e0");
        rd_entry("t2_e1");
        set_cta('h1FF);
        rd_entry("t1_e1ff");

        wcram('h40, 'h011);
        bwr(4, 'h22);
        bwr(5, 'h01);
        bwr(4, 'h33);
        bwr(5, 'h00);
        set_cta('h40);
        @(posedge clock); #1;
        bus.A = 3'd5;
        bus.CS_n = 1'b0;
        bus.RD_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.bus_en = (i % 2 == 0);
            @(posedge clock); #1;
        end
        bus.bus_en = 1'b1;
        bus.RD_n = 1'b1;
        bus.CS_n = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        mcta = (mcta + 1) % DEPTH;
        rd_entry("t3_once");
        rd_entry("t3_next");

        for (int i = 0; i < 20; i++) begin
            a = $urandom_range(16, 500);
            v = $urandom_range(0, 511);
            wcram(a, v);
        end
        for (int i = 0; i < 6; i++) begin
            x = written[$urandom_range(0, written.size() - 1)];
            set_cta(x);
            rd_entry("rnd_rd");
        end

        chk_rate(0, 4, "t4_m0");
        chk_rate(1, 3, "t4_m1");
        chk_rate(2, 2, "t4_m2");
        chk_rate(3, 2, "t4_m3");
        chk_rate(0, 4, "t4_back");

        wcram(7, 'h1FF);
        pstep(7, 1, 1, 0, "t5_flush");
        pstep(7, 0, 1, 1, "t5_white");
        pstep(7, 1, 1, 1, "t5_hblank");
        pstep(7, 1, 0, 1, "t5_white2");
        pstep(7, 1, 1, 1, "t5_vblank");
        pstep(7, 1, 1, 1, "t5_white3");

        wcram(9, 'h110);
        bwr(0, 'h80);
        pstep(9, 1, 1, 0, "t6_flush");
        pstep(9, 1, 1, 1, "t6_grey");
        pstep(9, 1, 1, 1, "t6_grey2");
        wcram(9, 'h1FF);
        pstep(9, 1, 1, 0, "t6_flush2");
        pstep(9, 1, 1, 1, "t6_newcol");

        for (int blk = 0; blk < 3; blk++) begin
            bwr(0, ($urandom_range(0, 1) << 7) | $urandom_range(0, 3));
            pstep(9, 1, 1, 0, "rnd_flush");
            for (int i = 0; i < 15; i++) begin
                x = written[$urandom_range(0, written.size() - 1)];
                pstep(x, ($urandom_range(0, 3) != 0) ? 1 : 0,
                      ($urandom_range(0, 3) != 0) ? 1 : 0, 1, "rnd_pix");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
